seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/quotient/remainder width in bits.
REQ-002 SHALL have parameter CTRWIDTH, default 4, iteration-counter width; SHALL satisfy 2^CTRWIDTH > WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a division; sampled on rising clk.
REQ-006 SHALL have port a  input  WIDTH  dividend, two's complement; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  divisor, two's complement; sampled with start.
REQ-008 SHALL have port q  output  WIDTH  quotient, two's complement.
REQ-009 SHALL have port r  output  WIDTH  remainder, two's complement.
REQ-010 SHALL have port busy  output  1  high while an iteration is in progress.
REQ-011 SHALL have port rdy  output  1  high while q/r/dbz/ovf hold a valid result.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag for the current result.
REQ-013 SHALL have port ovf  output  1  overflow flag (most-negative / -1) for the current result.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-015 IDLE or DONE with start=1 at an edge SHALL capture a and b, take their magnitudes, record result signs, clear rdy, and enter BUSY.
REQ-016 BUSY SHALL perform one restoring shift-subtract step per cycle, for exactly WIDTH cycles, counted by an internal counter.
REQ-017 After the WIDTH-th step the FSM SHALL apply the signs, drive q/r/flags, and enter DONE with rdy=1 and busy=0.
REQ-018 Latency SHALL be fixed: with start sampled at edge k, rdy SHALL be high after edge k+WIDTH+1, independent of operand values.
REQ-019 start SHALL be ignored while in BUSY; operands SHALL not change mid-operation.
REQ-020 DONE SHALL hold q, r, dbz, ovf and rdy stable until the next accepted start or reset; with no start, DONE SHALL persist.
REQ-021 Quotient SHALL truncate toward zero; remainder sign SHALL equal dividend sign; a = q*b + r with |r| < |b|.
REQ-022 b=0 SHALL give dbz=1, q = all ones (-1), r = a, ovf=0, with the same latency.
REQ-023 a = most-negative, b = -1 SHALL give ovf=1, q = most-negative, r = 0, dbz=0.
REQ-024 Internal magnitude arithmetic SHALL use WIDTH+1 bits so the most-negative operand magnitude is representable.
REQ-025 In IDLE, busy=0 and rdy=0; in BUSY, busy=1 and rdy=0; busy and rdy SHALL never both be 1.

Reset
REQ-026 reset=1 SHALL immediately, without waiting for clk, force state IDLE, counter 0, and q, r, busy, rdy, dbz, ovf all 0.
REQ-027 reset asserted mid-BUSY SHALL abort the operation with no partial result visible on any output.
REQ-028 After reset deasserts, the first start SHALL be accepted and behave as in REQ-015.

Structure
REQ-029 WIDTH/CTRWIDTH defaults and FSM state encodings SHALL be in the shared definitions include file used by the arithmetic blocks.
REQ-030 One sub-module, div_step, SHALL be provided: combinational single restoring step (partial remainder, divisor magnitude -> next partial remainder, quotient bit), instantiated once.
REQ-031 The design SHALL be synthesizable RTL with no latches and no combinational path from inputs to outputs.

Verification
REQ-032 a=100, b=7, start one cycle -> rdy high after edge k+9; q=14 (8'h0E), r=2, dbz=0, ovf=0.
REQ-033 a=-100, b=7 -> q=-14 (8'hF2), r=-2 (8'hFE); a=100, b=-7 -> q=8'hF2, r=2.
REQ-034 a=5, b=0 -> dbz=1, q=8'hFF, r=5, same latency; a=-128, b=-1 -> ovf=1, q=8'h80, r=0.
REQ-035 Start 100/7, reassert start with a=9, b=3 during BUSY -> ignored, result still q=14, r=2.
REQ-036 Reset asserted 4 cycles into BUSY -> all outputs 0 immediately; subsequent start with 50/5 -> q=10, r=0.
REQ-037 Randomized: 1000 random a/b pairs checked against a signed reference model; the bench SHALL also assert the busy/rdy exclusivity of REQ-025 on every cycle.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential signed divider: default widths and
// the FSM state encoding used by the control and arithmetic blocks.
package seq_div_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CTRWIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_if.sv
// Request/result bundle of the divider: operands and start in, quotient,
// remainder, status and flags out.
interface seq_div_if
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             rdy;
  logic             dbz;
  logic             ovf;

  modport master (
    output start, a, b,
    input  q, r, busy, rdy, dbz, ovf
  );

  modport slave (
    input  start, a, b,
    output q, r, busy, rdy, dbz, ovf
  );

endinterface

// File: rtl/seq_div_div_step.sv
// One combinational restoring division step: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
module div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH:0]   i_dvs,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;

  // Trial subtraction in WIDTH+1 bits; keep the difference only if non-negative.
  always_comb begin
    w_shift = {i_rem, i_bit};
    o_qbit  = (w_shift >= i_dvs);
    o_rem   = w_shift[WIDTH-1:0];
    if (o_qbit) begin
      o_rem = WIDTH'(w_shift - i_dvs);
    end
  end

endmodule

// File: rtl/seq_div.sv
// Sequential signed divider: WIDTH restoring steps on operand magnitudes,
// then one finalize cycle applying signs and special cases (b=0, MIN/-1).
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CTRWIDTH = DEF_CTRWIDTH
) (
  input logic   clk,
  input logic   reset,
  seq_div_if.slave bus
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t              r_state;
  state_t              w_next;
  logic [CTRWIDTH-1:0] r_cnt;
  logic [WIDTH-1:0]    r_quo;
  logic [WIDTH-1:0]    r_rem;
  logic [WIDTH:0]      r_dvs;
  logic [WIDTH-1:0]    r_a;
  logic                r_qneg;
  logic                r_rneg;
  logic                r_dbz_p;
  logic                r_ovf_p;
  logic [WIDTH-1:0]    r_q;
  logic [WIDTH-1:0]    r_r;
  logic                r_dbz;
  logic                r_ovf;

  logic                w_accept;
  logic                w_last;
  logic [WIDTH:0]      w_aext;
  logic [WIDTH:0]      w_bext;
  logic [WIDTH-1:0]    w_amag;
  logic [WIDTH:0]      w_bmag;
  logic [WIDTH-1:0]    w_rem_nx;
  logic                w_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_dvs  (r_dvs),
    .i_bit  (r_quo[WIDTH-1]),
    .o_rem  (w_rem_nx),
    .o_qbit (w_qbit)
  );

  // Operand magnitudes, computed in WIDTH+1 bits so MOST_NEG is representable.
  always_comb begin
    w_aext   = {bus.a[WIDTH-1], bus.a};
    w_bext   = {bus.b[WIDTH-1], bus.b};
    w_amag   = WIDTH'(bus.a[WIDTH-1] ? -w_aext : w_aext);
    w_bmag   = bus.b[WIDTH-1] ? -w_bext : w_bext;
    w_accept = bus.start && (r_state != S_BUSY);
    w_last   = (r_cnt == CTRWIDTH'(WIDTH));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: start accepted from IDLE/DONE, BUSY ends after the last step.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_BUSY;
      S_BUSY:  if (w_last)    w_next = S_DONE;
      S_DONE:  if (bus.start) w_next = S_BUSY;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture operands, iterate, then finalize signed results and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_a     <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_dbz_p <= 1'b0;
      r_ovf_p <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_quo   <= w_amag;
      r_rem   <= '0;
      r_dvs   <= w_bmag;
      r_a     <= bus.a;
      r_qneg  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      r_rneg  <= bus.a[WIDTH-1];
      r_dbz_p <= (bus.b == '0);
      r_ovf_p <= (bus.a == MOST_NEG) && (bus.b == '1);
    end else if (r_state == S_BUSY) begin
      if (!w_last) begin
        r_rem <= w_rem_nx;
        r_quo <= {r_quo[WIDTH-2:0], w_qbit};
        r_cnt <= r_cnt + 1'b1;
      end else if (r_dbz_p) begin
        r_q   <= '1;
        r_r   <= r_a;
        r_dbz <= 1'b1;
        r_ovf <= 1'b0;
      end else if (r_ovf_p) begin
        r_q   <= MOST_NEG;
        r_r   <= '0;
        r_dbz <= 1'b0;
        r_ovf <= 1'b1;
      end else begin
        r_q   <= r_qneg ? -r_quo : r_quo;
        r_r   <= r_rneg ? -r_rem : r_rem;
        r_dbz <= 1'b0;
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.q    = r_q;
  assign bus.r    = r_r;
  assign bus.dbz  = r_dbz;
  assign bus.ovf  = r_ovf;
  assign bus.busy = (r_state == S_BUSY);
  assign bus.rdy  = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed corner cases with literal
// expectations plus randomized operands against a signed arithmetic model.
module tb_seq_div;

  logic clk;
  logic reset;

  seq_div_if #(.WIDTH(8)) bus ();

  seq_div #(.WIDTH(8), .CTRWIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q, exp_r;
  logic       exp_dbz, exp_ovf;
  bit         exp_valid = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: plain signed integer division with the two special cases.
  task automatic model(input logic [7:0] a, input logic [7:0] b);
    int ia;
    int ib;
    ia = $signed(a);
    ib = $signed(b);
    exp_dbz = 1'b0;
    exp_ovf = 1'b0;
    if (ib == 0) begin
      exp_q   = 8'hFF;
      exp_r   = a;
      exp_dbz = 1'b1;
    end else if (ia == -128 && ib == -1) begin
      exp_q   = 8'h80;
      exp_r   = 8'h00;
      exp_ovf = 1'b1;
    end else begin
      exp_q = 8'(ia / ib);
      exp_r = 8'(ia % ib);
    end
  endtask

  // Every cycle: busy/rdy exclusivity, and result check whenever rdy is up.
  always @(negedge clk) begin
    if (!reset) begin
      chk("busy_rdy_excl", {31'b0, bus.busy & bus.rdy}, 32'd0);
      if (bus.rdy && exp_valid) begin
        chk("q",   {24'b0, bus.q},   {24'b0, exp_q});
        chk("r",   {24'b0, bus.r},   {24'b0, exp_r});
        chk("dbz", {31'b0, bus.dbz}, {31'b0, exp_dbz});
        chk("ovf", {31'b0, bus.ovf}, {31'b0, exp_ovf});
      end
    end
  end

  task automatic do_div(input logic [7:0] a, input logic [7:0] b, input bit inject);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    model(a, b);
    exp_valid = 1;
    bus.start = 1'b0;
    chk("busy_after_start", {31'b0, bus.busy}, 32'd1);
    cyc = 0;
    while (!bus.rdy && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (inject && cyc == 2) begin
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd3;
      end
      if (inject && cyc == 4) bus.start = 1'b0;
    end
    chk("latency", cyc, 32'd9);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_q"},    {24'b0, bus.q},    32'd0);
    chk({tag, "_r"},    {24'b0, bus.r},    32'd0);
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, "_rdy"},  {31'b0, bus.rdy},  32'd0);
    chk({tag, "_dbz"},  {31'b0, bus.dbz},  32'd0);
    chk({tag, "_ovf"},  {31'b0, bus.ovf},  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Hand-computed expectations.
    do_div(8'd100, 8'd7, 0);
    chk("lit_100_7_q", {24'b0, bus.q}, 32'h0E);
    chk("lit_100_7_r", {24'b0, bus.r}, 32'h02);
    do_div(8'h9C, 8'd7, 0);
    chk("lit_m100_7_q", {24'b0, bus.q}, 32'hF2);
    chk("lit_m100_7_r", {24'b0, bus.r}, 32'hFE);
    do_div(8'd100, 8'hF9, 0);
    chk("lit_100_m7_q", {24'b0, bus.q}, 32'hF2);
    chk("lit_100_m7_r", {24'b0, bus.r}, 32'h02);
    do_div(8'd5, 8'd0, 0);
    chk("lit_dbz_flag", {31'b0, bus.dbz}, 32'd1);
    chk("lit_dbz_q",    {24'b0, bus.q},   32'hFF);
    chk("lit_dbz_r",    {24'b0, bus.r},   32'h05);
    do_div(8'h80, 8'hFF, 0);
    chk("lit_ovf_flag", {31'b0, bus.ovf}, 32'd1);
    chk("lit_ovf_q",    {24'b0, bus.q},   32'h80);
    chk("lit_ovf_r",    {24'b0, bus.r},   32'h00);

    // start during BUSY is ignored.
    do_div(8'd100, 8'd7, 1);
    chk("ignore_q", {24'b0, bus.q}, 32'h0E);
    chk("ignore_r", {24'b0, bus.r}, 32'h02);

    // DONE persists without a new start.
    repeat (5) @(negedge clk);
    chk("done_hold_rdy", {31'b0, bus.rdy}, 32'd1);
    chk("done_hold_q",   {24'b0, bus.q},   32'h0E);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd100;
    bus.b     = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    exp_valid = 0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    do_div(8'd50, 8'd5, 0);
    chk("post_reset_q", {24'b0, bus.q}, 32'h0A);
    chk("post_reset_r", {24'b0, bus.r}, 32'h00);

    // Randomized operands with occasional corner values.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 19))
        0: rb = 8'h00;
        1: begin ra = 8'h80; rb = 8'hFF; end
        2: ra = 8'h80;
        3: rb = 8'h80;
        default: ;
      endcase
      do_div(ra, rb, 0);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
